// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the tiny CPU core and its instruction sequencer.
package tt_cpu_pkg;

    localparam int IW = 6;
    localparam int AW = 4;

    typedef logic [IW-1:0] instr_t;

    localparam instr_t NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: register file with synchronous write and asynchronous read.
module prog_mem #(
    parameter int IW    = 6,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-feed stage: loads a program from the pins and plays it to the
// core one word per clock, following conditional jumps reported by the core.
module instr_sequencer
    import tt_cpu_pkg::*;
#(
    parameter int IW    = tt_cpu_pkg::IW,
    parameter int AW    = tt_cpu_pkg::AW,
    parameter int DEPTH = 16,
    parameter bit WRAP  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic          load_last,
    input  logic [IW-1:0] load_data,
    output logic          load_ready,
    input  logic          run_start,
    input  logic          stop,
    input  logic          cjump,
    input  logic [AW-1:0] jump_target,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted,
    output logic [AW:0]   prog_len
);

    localparam logic [AW:0] ONE_L = {{AW{1'b0}}, 1'b1};

    seq_state_t    state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] raddr;
    logic [IW-1:0] rdata;
    logic          mem_we;
    logic          at_last;
    logic          jump_ok;
    logic [AW:0]   last_pc;

    assign mem_we  = (state == LOAD) && load_valid;
    assign last_pc = prog_len - ONE_L;
    assign at_last = ({1'b0, pc} == last_pc);
    assign jump_ok = ({1'b0, jump_target} < prog_len);

    prog_mem #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr),
        .wdata (load_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Address of the word that becomes instr next cycle; one shared read port.
    always_comb begin
        raddr = pc + AW'(1);
        if (state != RUN)   raddr = '0;
        else if (cjump)     raddr = jump_target;
        else if (at_last)   raddr = '0;
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            instr      <= NOP;
            running    <= 1'b0;
            halted     <= 1'b0;
            load_ready <= 1'b0;
            prog_len   <= '0;
            wptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        wptr       <= '0;
                        prog_len   <= '0;
                    end else if (run_start && prog_len != '0) begin
                        state   <= RUN;
                        running <= 1'b1;
                        pc      <= '0;
                        instr   <= rdata;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        wptr <= wptr + AW'(1);
                        // Full memory ends the load so nothing past DEPTH is written.
                        if (load_last || wptr == AW'(DEPTH - 1)) begin
                            state      <= IDLE;
                            load_ready <= 1'b0;
                            prog_len   <= {1'b0, wptr} + ONE_L;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        instr   <= NOP;
                    end else if (cjump) begin
                        if (jump_ok) begin
                            pc    <= jump_target;
                            instr <= rdata;
                        end else begin
                            state   <= HALT;
                            running <= 1'b0;
                            halted  <= 1'b1;
                            instr   <= NOP;
                        end
                    end else if (at_last) begin
                        if (WRAP) begin
                            pc    <= '0;
                            instr <= rdata;
                        end else begin
                            state   <= HALT;
                            running <= 1'b0;
                            halted  <= 1'b1;
                            instr   <= NOP;
                        end
                    end else begin
                        pc    <= pc + AW'(1);
                        instr <= rdata;
                    end
                end
                HALT: begin
                    instr <= NOP;
                    if (stop) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction-feed stage directly upstream of the tiny CPU core. It takes the core's instr[5:0] input and its cjump output.
- Holds a small program memory, loaded word-by-word from the TinyTapeout input pins.
- Plays the program to the core one instruction per clock.
- Redirects its program counter when the core signals a conditional jump.
- Replaces hand-driven instr stimulus in silicon and in the bench.

Parameters:
IW, 6, instruction width (matches core instr port)
AW, 4, program-counter / address width
DEPTH, 16, program memory words (must equal 2**AW)
WRAP, 1, 1 = restart at address 0 after the last word; 0 = halt

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  pulse in IDLE: begin program load
load_valid  input  1  load_data valid this cycle
load_last  input  1  qualifies load_valid: this word is the final one
load_data  input  IW  program word to write
load_ready  output  1  high while in LOAD (word accepted when valid and ready)
run_start  input  1  pulse in IDLE: begin execution at address 0
stop  input  1  return to IDLE from RUN or HALT
cjump  input  1  from core: take jump this cycle
jump_target  input  AW  jump destination, sampled when cjump=1 (core io_out[AW-1:0])
instr  output  IW  registered instruction to core
pc  output  AW  address of the word currently on instr
running  output  1  high in RUN
halted  output  1  high in HALT
prog_len  output  AW+1  number of words loaded (0..DEPTH)

Behaviour:
- Reset values: state=IDLE; pc=0; instr=NOP (all zeros); running=0; halted=0; load_ready=0; prog_len=0; write pointer=0. Memory contents are not reset. Reset in any state, including mid-LOAD, forces prog_len=0.
- State machine: IDLE, LOAD, RUN, HALT.
- IDLE transitions:
  - load_start → LOAD, write pointer=0, prog_len=0.
  - run_start with prog_len>0 → RUN.
  - run_start with prog_len=0 is ignored.
  - load_start and run_start together: load wins.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1: mem[wptr]=load_data, wptr++.
  - If load_last=1, or wptr==DEPTH-1 (memory full): prog_len=wptr+1 and → IDLE next cycle. Words beyond DEPTH are never written.
  - load_valid=0 cycles stall with no effect.
  - run_start and stop are ignored in LOAD.
- RUN entry, one cycle of latency: on the cycle after run_start, instr=mem[0], pc=0, running=1.
- RUN, each cycle, priority order:
  1. stop → IDLE, instr=NOP, running=0.
  2. cjump=1:
     - jump_target < prog_len: pc=jump_target, instr=mem[jump_target].
     - otherwise: → HALT with instr=NOP.
  3. pc==prog_len-1:
     - WRAP=1: pc=0, instr=mem[0].
     - WRAP=0: → HALT, instr=NOP.
  4. Otherwise pc=pc+1, instr=mem[pc+1].
- A jump on the last word takes precedence over wrap/halt.
- HALT: halted=1, instr=NOP, pc holds. stop → IDLE. run_start is ignored until stop.
- Arithmetic: pc increments modulo 2**AW, but the end-of-program check guarantees it never reaches prog_len. prog_len is AW+1 bits so it can represent DEPTH.
- instr and pc are always registered; there is no combinational path from cjump to instr.

Decomposition:
- Package tt_cpu_pkg holds:
  - IW and AW constants
  - NOP constant (IW'b0)
  - sequencer state enum {IDLE, LOAD, RUN, HALT}
  - the shared instr typedef, used by the core as well
- Sub-module prog_mem: DEPTH×IW register file with synchronous write and asynchronous read. The sequencer registers the read data into instr.

Test Plan:
- Reset then load 4 words 0x11,0x22,0x33,0x04, with load_last on the 4th, then run_start → prog_len=4; instr sequence over 4 cycles is 0x11,0x22,0x33,0x04 with pc 0..3; with WRAP=1, 0x11 follows.
- WRAP=0 build, same program → after 0x04, halted=1 and instr=0x00 held; stop → IDLE, running=0.
- Run a 4-word program, assert cjump with jump_target=1 while pc=2 → next cycle pc=1, instr=0x22, then 0x33. Same with jump_target=7 (≥prog_len) → HALT, instr=0x00.
- Load 20 words with load_last never asserted → exactly 16 written, load_ready drops after the 16th, prog_len=16; run plays all 16 words.
- run_start with prog_len=0 → stays IDLE, running=0. load_start and run_start in the same cycle → LOAD entered.
- Assert rst during LOAD after 2 words → next cycle IDLE, prog_len=0, instr=0x00. Assert rst during RUN → pc=0, running=0.
